// File: rtl/card_shoe_if.sv
// Card shoe request/response bundle: consumer drives SHUFFLE/USED, shoe drives card status.
interface card_shoe_if;
    localparam int unsigned VAL_W = 4;
    localparam int unsigned CNT_W = 6;

    logic             SHUFFLE;
    logic             USED;
    logic [VAL_W-1:0] RND;
    logic             RDY;
    logic             EMPTY;
    logic             BUSY;
    logic [CNT_W-1:0] REMAIN;

    modport master (output SHUFFLE, USED, input RND, RDY, EMPTY, BUSY, REMAIN);
    modport slave  (input SHUFFLE, USED, output RND, RDY, EMPTY, BUSY, REMAIN);
endinterface

// File: rtl/card_shoe.sv
// Card shoe: fills a 52-card blackjack-valued deck, shuffles it with
// rejection-sampled Fisher-Yates driven by a free-running LFSR, then deals
// one card per accepted USED pulse.
module card_shoe #(
    parameter int unsigned DECK_SIZE = 52,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        CLK,
    input  logic        RST_N,
    card_shoe_if.slave  bus
);
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned VAL_W  = 4;
    localparam int unsigned CNT_W  = 6;
    localparam logic [CNT_W-1:0]  LAST = CNT_W'(DECK_SIZE - 1);
    localparam logic [CNT_W-1:0]  FULL = CNT_W'(DECK_SIZE);
    localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

    typedef enum logic [1:0] {FILL, SHUF, SERVE, DONE} state_t;

    state_t            state;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic [CNT_W-1:0]  ptr;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cand;
    logic              accept;
    logic [VAL_W-1:0]  deck [DECK_SIZE];

    // Galois step for x^16+x^14+x^13+x^11+1; the candidate index is the low six bits.
    assign lfsr_next = {1'b0, lfsr[LFSR_W-1:1]} ^ (lfsr[0] ? TAPS : '0);
    assign cand      = lfsr[CNT_W-1:0];
    assign accept    = (cand <= idx);

    // Deck storage: rewritten wholesale in FILL, one swap per accepted candidate in SHUF.
    always_ff @(posedge CLK) begin
        if (state == FILL) begin
            for (int k = 0; k < int'(DECK_SIZE); k++) begin
                deck[k] <= ((k % 13) >= 9) ? VAL_W'(10) : VAL_W'((k % 13) + 1);
            end
        end else if (state == SHUF && accept) begin
            deck[idx]  <= deck[cand];
            deck[cand] <= deck[idx];
        end
    end

    // Control FSM with registered status outputs computed from next-cycle values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= FILL;
            lfsr       <= SEED;
            ptr        <= '0;
            idx        <= LAST;
            bus.RDY    <= 1'b0;
            bus.RND    <= '0;
            bus.EMPTY  <= 1'b0;
            bus.REMAIN <= '0;
            bus.BUSY   <= 1'b1;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                FILL: begin
                    idx   <= LAST;
                    ptr   <= '0;
                    state <= SHUF;
                end
                SHUF: begin
                    if (accept) begin
                        if (idx == CNT_W'(1)) begin
                            // Last swap touches deck[0] only when the candidate is 0.
                            state      <= SERVE;
                            ptr        <= '0;
                            bus.BUSY   <= 1'b0;
                            bus.RDY    <= 1'b1;
                            bus.REMAIN <= FULL;
                            bus.RND    <= (cand == '0) ? deck[1] : deck[0];
                        end else begin
                            idx <= idx - CNT_W'(1);
                        end
                    end
                end
                SERVE: begin
                    if (bus.SHUFFLE) begin
                        state      <= FILL;
                        bus.RDY    <= 1'b0;
                        bus.RND    <= '0;
                        bus.REMAIN <= '0;
                        bus.BUSY   <= 1'b1;
                    end else if (bus.USED) begin
                        if (ptr == LAST) begin
                            state      <= DONE;
                            ptr        <= FULL;
                            bus.RDY    <= 1'b0;
                            bus.RND    <= '0;
                            bus.EMPTY  <= 1'b1;
                            bus.REMAIN <= '0;
                        end else begin
                            ptr        <= ptr + CNT_W'(1);
                            bus.RND    <= deck[ptr + CNT_W'(1)];
                            bus.REMAIN <= FULL - ptr - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.SHUFFLE) begin
                        state     <= FILL;
                        bus.EMPTY <= 1'b0;
                        bus.BUSY  <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_card_shoe.sv
// Randomized bench for card_shoe against a spec-level shuffle/deal model.
module tb_card_shoe;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int          N    = 52;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    card_shoe_if bus ();

    card_shoe #(.DECK_SIZE(N), .SEED(SEED)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_lfsr;
    int          exp_deck [N];
    int          exp_len;
    int          ptr;
    int          got      [N];
    int          pu_deck  [N];
    int          deck_a   [N];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Free-running generator reference, reset alongside the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Whole shuffle as the algorithm reads: fresh ordered deck, candidates from successive LFSR values.
    task automatic build_model(input logic [15:0] l_fill);
        logic [15:0] l;
        int i, c, t;
        for (int k = 0; k < N; k++) exp_deck[k] = ((k % 13) + 1 > 10) ? 10 : (k % 13) + 1;
        l = l_fill;
        i = N - 1;
        exp_len = 0;
        while (i > 0) begin
            l = lfsr_step(l);
            exp_len++;
            c = int'(l[5:0]);
            if (c <= i) begin
                t = exp_deck[i]; exp_deck[i] = exp_deck[c]; exp_deck[c] = t;
                i--;
            end
        end
    endtask

    // Called at a negedge inside the FILL cycle; optionally pokes ignored USED/SHUFFLE while busy.
    task automatic wait_ready(input string tag, input bit poke);
        int cyc = 0;
        build_model(m_lfsr);
        check({tag, "_fill_busy"}, int'(bus.BUSY), 1);
        check({tag, "_fill_remain"}, int'(bus.REMAIN), 0);
        while (bus.BUSY === 1'b1 && cyc < 5000) begin
            if (poke) begin
                bus.USED    = 1'($urandom_range(0, 1));
                bus.SHUFFLE = 1'($urandom_range(0, 1));
            end
            cyc++;
            @(negedge clk);
        end
        bus.USED    = 1'b0;
        bus.SHUFFLE = 1'b0;
        check({tag, "_busy_cycles"}, cyc, exp_len + 1);
        check({tag, "_rdy"}, int'(bus.RDY), 1);
        check({tag, "_empty"}, int'(bus.EMPTY), 0);
        check({tag, "_remain"}, int'(bus.REMAIN), N);
        check({tag, "_first"}, int'(bus.RND), exp_deck[0]);
        ptr = 0;
    endtask

    // Deal n cards, holding USED or with random gaps, checking every cycle.
    task automatic serve(input string tag, input int n, input bit gaps);
        int  dealt = 0;
        int  guard = 0;
        bit  u;
        while (dealt < n && guard < 1000) begin
            check({tag, "_rdy"}, int'(bus.RDY), 1);
            check({tag, "_rnd"}, int'(bus.RND), exp_deck[ptr]);
            check({tag, "_remain"}, int'(bus.REMAIN), N - ptr);
            u = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.USED = u;
            got[ptr] = int'(bus.RND);
            @(negedge clk);
            if (u) begin
                ptr++;
                dealt++;
            end
            guard++;
        end
        bus.USED = 1'b0;
        check({tag, "_dealt"}, dealt, n);
    endtask

    task automatic check_empty(input string tag);
        check({tag, "_empty"}, int'(bus.EMPTY), 1);
        check({tag, "_rdy"}, int'(bus.RDY), 0);
        check({tag, "_remain"}, int'(bus.REMAIN), 0);
        check({tag, "_rnd"}, int'(bus.RND), 0);
        check({tag, "_busy"}, int'(bus.BUSY), 0);
    endtask

    task automatic check_multiset(input string tag);
        int hist [11];
        int sum = 0;
        foreach (hist[v]) hist[v] = 0;
        for (int k = 0; k < N; k++) begin
            if (got[k] >= 1 && got[k] <= 10) hist[got[k]]++;
            sum += got[k];
        end
        for (int v = 1; v <= 9; v++) check($sformatf("%s_count%0d", tag, v), hist[v], 4);
        check({tag, "_count10"}, hist[10], 16);
        check({tag, "_sum"}, sum, 340);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy"}, int'(bus.RDY), 0);
        check({tag, "_rnd"}, int'(bus.RND), 0);
        check({tag, "_empty"}, int'(bus.EMPTY), 0);
        check({tag, "_remain"}, int'(bus.REMAIN), 0);
        check({tag, "_busy"}, int'(bus.BUSY), 1);
    endtask

    task automatic compare_deck(input string tag, input int ref_d [N]);
        int diff = 0;
        for (int k = 0; k < N; k++) if (got[k] != ref_d[k]) diff++;
        check(tag, diff, 0);
    endtask

    // From SERVE or DONE at a negedge: one-cycle SHUFFLE, returns inside the FILL cycle.
    task automatic do_shuffle();
        bus.SHUFFLE = 1'b1;
        @(negedge clk);
        bus.SHUFFLE = 1'b0;
    endtask

    // Asynchronous reset away from any edge, outputs checked before the next clock.
    task automatic hit_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset(tag);
        @(negedge clk);
        check_reset({tag, "_held"});
        rst_n = 1'b1;
    endtask

    initial begin
        int diff;
        bus.USED    = 1'b0;
        bus.SHUFFLE = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        wait_ready("pu", 1'b0);
        serve("pu_drain", N, 1'b0);
        pu_deck = got;
        check_multiset("pu");
        check_empty("pu_done");

        bus.USED = 1'b1;
        repeat (2) @(negedge clk);
        bus.USED = 1'b0;
        check_empty("used_in_done");

        do_shuffle();
        wait_ready("poke", 1'b1);
        serve("part20", 20, 1'b1);
        check("part20_remain32", int'(bus.REMAIN), 32);
        bus.SHUFFLE = 1'b1;
        bus.USED    = 1'b1;
        @(negedge clk);
        bus.SHUFFLE = 1'b0;
        bus.USED    = 1'b0;
        check("collide_busy", int'(bus.BUSY), 1);
        check("collide_rdy", int'(bus.RDY), 0);
        wait_ready("mid", 1'b0);
        serve("mid_drain", N, 1'b1);
        check_multiset("mid");
        check_empty("mid_done");

        do_shuffle();
        repeat ($urandom_range(2, 40)) @(negedge clk);
        hit_reset("rst_shuf");
        wait_ready("rst_shuf", 1'b0);
        serve("rst_shuf_drain", N, 1'b0);
        compare_deck("rst_shuf_same_as_pu", pu_deck);

        do_shuffle();
        wait_ready("pre10", 1'b0);
        serve("pre10", 10, 1'b1);
        hit_reset("rst_serve");
        wait_ready("rst_serve", 1'b0);
        serve("rst_serve_drain", N, 1'b1);
        compare_deck("rst_serve_same_as_pu", pu_deck);
        check_empty("rst_serve_done");

        do_shuffle();
        wait_ready("det_a", 1'b0);
        serve("det_a", N, 1'b0);
        deck_a = got;
        check_multiset("det_a");
        check_empty("det_a_done");
        do_shuffle();
        wait_ready("det_b", 1'b0);
        serve("det_b", N, 1'b0);
        check_multiset("det_b");
        check_empty("det_b_done");
        diff = 0;
        for (int k = 0; k < N; k++) if (got[k] != deck_a[k]) diff++;
        check("det_orders_differ", int'(diff != 0), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
